// File: rtl/piso_ser_tx.sv
// piso_ser_tx: parallel-in serial-out transmitter.
// Takes one WIDTH-bit word through a valid/ready handshake and shifts it out
// LSB first on s_out. Each bit is held for DIV clocks. s_en marks the last
// clock of every bit period so that a downstream shift-right receiver,
// clock-enabled by s_en, assembles the original word after WIDTH bits.
//
// Handshake: a word is transferred on a rising edge where load_valid and
// load_ready are both high. load_ready is high only while idle, and p_in is
// sampled only on that edge. load_valid while a frame is in flight is ignored;
// nothing is queued.
//
// dbg_state exposes the FSM state (0 = IDLE, 1 = SHIFT) for observation.
module piso_ser_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] p_in,
  output logic             s_out,
  output logic             s_en,
  output logic             busy,
  output logic             done,
  output logic             dbg_state
);

  // Counter widths: at least one bit, even when DIV is 1.
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Terminal counts. Neither counter ever moves past its terminal value.
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [DCW-1:0]   div_cnt_q;
  logic [BCW-1:0]   bit_cnt_q;
  logic             done_q;

  logic [WIDTH-1:0] shreg_d;
  logic [DCW-1:0]   div_cnt_d;
  logic [BCW-1:0]   bit_cnt_d;
  logic             bit_end;

  // Datapath helpers: next shift-register value and counter increments.
  always_comb begin
    shreg_d   = shreg_q >> 1;
    div_cnt_d = div_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q + 1'b1;
  end

  // End of the current bit period. Only meaningful in SHIFT; gating by state
  // matters when DIV is 1, where the divider compare is always true.
  assign bit_end = (state_q == SHIFT) && (div_cnt_q == DIV_LAST);

  // Transmit FSM: load on accept, shift one bit per DIV clocks, pulse done
  // in the first idle cycle after the last bit. Reset aborts any frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            shreg_q   <= p_in;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_end) begin
            // Zero fill leaves shreg at 0 once all bits are out, so s_out
            // drops to 0 in IDLE without extra gating.
            shreg_q   <= shreg_d;
            div_cnt_q <= '0;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= IDLE;
              done_q    <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_d;
            end
          end else begin
            div_cnt_q <= div_cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // All outputs come straight from flops or from a compare of flops.
  assign s_out      = shreg_q[0];
  assign s_en       = bit_end;
  assign busy       = (state_q == SHIFT);
  assign load_ready = (state_q == IDLE);
  assign done       = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_piso_ser_tx.sv
// Bench for piso_ser_tx: one instance with DIV=1, one with DIV=3.
// A frame-level model predicts every output from the time of acceptance,
// and a shift-right receiver rebuilds words from s_out/s_en.
module tb_piso_ser_tx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic       lv1 = 1'b0, lv3 = 1'b0;
  logic [7:0] p1 = 8'h00, p3 = 8'h00;
  logic r1, so1, se1, b1, d1, st1;
  logic r3, so3, se3, b3, d3, st3;

  piso_ser_tx #(.WIDTH(8), .DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv1), .load_ready(r1), .p_in(p1),
    .s_out(so1), .s_en(se1), .busy(b1), .done(d1), .dbg_state(st1)
  );

  piso_ser_tx #(.WIDTH(8), .DIV(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv3), .load_ready(r3), .p_in(p3),
    .s_out(so3), .s_en(se3), .busy(b3), .done(d3), .dbg_state(st3)
  );

  logic [1:0] rv, sov, sev, bv, dv, stv;
  assign rv  = {r3, r1};
  assign sov = {so3, so1};
  assign sev = {se3, se1};
  assign bv  = {b3, b1};
  assign dv  = {d3, d1};
  assign stv = {st3, st1};

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame model ----------------
  // mt[d] = cycles elapsed since the accepting edge (0 = first cycle of
  // bit 0), -1 when no frame is pending. mw[d] = accepted word.
  int         mt[2];
  logic [7:0] mw[2];
  initial begin
    mt[0] = -1; mt[1] = -1;
    mw[0] = 8'h00; mw[1] = 8'h00;
  end

  always @(posedge clk) begin
    int   n;
    logic lvd;
    logic [7:0] pd;
    for (int d = 0; d < 2; d++) begin
      n   = (d == 0) ? 8 : 24;
      lvd = (d == 0) ? lv1 : lv3;
      pd  = (d == 0) ? p1 : p3;
      if (!rst_n) begin
        mt[d] = -1;
      end else if ((mt[d] < 0 || mt[d] >= n) && lvd) begin
        mt[d] = 0;
        mw[d] = pd;
      end else if (mt[d] >= 0 && mt[d] <= n) begin
        mt[d] = mt[d] + 1;
      end
    end
  end

  // Compare every cycle against the model.
  always @(negedge clk) begin
    int    dv_div, n, t;
    logic  eb, es, ee, ed;
    string nm;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        dv_div = (d == 0) ? 1 : 3;
        n      = 8 * dv_div;
        t      = mt[d];
        nm     = (d == 0) ? "div1" : "div3";
        eb     = (t >= 0) && (t < n);
        es     = eb ? mw[d][t / dv_div] : 1'b0;
        ee     = eb && ((t % dv_div) == dv_div - 1);
        ed     = (t == n);
        chk({nm, ".busy"},       bv[d],  eb);
        chk({nm, ".load_ready"}, rv[d],  !eb);
        chk({nm, ".s_out"},      sov[d], es);
        chk({nm, ".s_en"},       sev[d], ee);
        chk({nm, ".done"},       dv[d],  ed);
        chk({nm, ".dbg_state"},  stv[d], eb);
      end
    end
  end

  // ---------------- loopback receivers and event counters ----------------
  logic [7:0] rx1 = 8'h00, rx3 = 8'h00;
  int en1 = 0, en3 = 0, dn1 = 0, dn3 = 0, ones3 = 0;
  always @(posedge clk) begin
    if (se1 === 1'b1) begin rx1 <= {so1, rx1[7:1]}; en1 <= en1 + 1; end
    if (se3 === 1'b1) begin rx3 <= {so3, rx3[7:1]}; en3 <= en3 + 1; end
    if (d1 === 1'b1) dn1 <= dn1 + 1;
    if (d3 === 1'b1) dn3 <= dn3 + 1;
    if (so3 === 1'b1) ones3 <= ones3 + 1;
  end

  // ---------------- driver tasks ----------------
  // Returns at the negedge of the first cycle after the accepting edge.
  task automatic send1(input logic [7:0] w);
    @(negedge clk);
    lv1 = 1'b1;
    p1  = w;
    @(negedge clk);
    lv1 = 1'b0;
  endtask

  // Waits (bounded) until done is seen on the selected instance.
  task automatic wait_done(input int d, input int budget, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (((d == 0) ? d1 : d3) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, seen, 1'b1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int   e0, n0, o0;
    logic exp_bits[8];
    logic es, ee, ed;
    exp_bits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset held for two edges.
    repeat (2) @(negedge clk);
    chk("rst.load_ready", r1, 1'b1);
    chk("rst.busy", b1, 1'b0);
    chk("rst.s_out", so1, 1'b0);
    chk("rst.s_en", se1, 1'b0);
    chk("rst.done", d1, 1'b0);
    chk("rst.div3_ready", r3, 1'b1);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // DIV=1, 8'hA5: bits 1,0,1,0,0,1,0,1 in cycles 1..8, done in cycle 9.
    e0 = en1; n0 = dn1;
    @(negedge clk);
    lv1 = 1'b1; p1 = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) lv1 = 1'b0;
      chk($sformatf("a5.bit%0d", k), so1, exp_bits[k]);
      chk($sformatf("a5.s_en%0d", k), se1, 1'b1);
      chk($sformatf("a5.done_early%0d", k), d1, 1'b0);
    end
    @(negedge clk);
    chk("a5.done_c9", d1, 1'b1);
    chk("a5.ready_c9", r1, 1'b1);
    @(negedge clk);
    chk("a5.done_c10", d1, 1'b0);
    chk("a5.rx", rx1, 8'hA5);
    chk("a5.en_count", en1 - e0, 8);
    chk("a5.done_count", dn1 - n0, 1);

    // Back-to-back loopback: 3C then C3 offered during the first frame.
    send1(8'h3C);
    lv1 = 1'b1;
    p1  = 8'hC3;
    wait_done(0, 40, "b2b.first_done");
    chk("b2b.rx_first", rx1, 8'h3C);
    @(negedge clk);
    lv1 = 1'b0;
    chk("b2b.busy_after_accept", b1, 1'b1);
    wait_done(0, 40, "b2b.second_done");
    chk("b2b.rx_second", rx1, 8'hC3);
    repeat (2) @(negedge clk);

    // DIV=3, 8'h01: s_out high cycles 1..3, s_en every 3rd, done at 25.
    e0 = en3; n0 = dn3; o0 = ones3;
    @(negedge clk);
    lv3 = 1'b1; p3 = 8'h01;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (c == 1) lv3 = 1'b0;
      es = (c <= 3);
      ee = (c % 3 == 0) && (c <= 24);
      ed = (c == 25);
      chk($sformatf("div3.s_out_c%0d", c), so3, es);
      chk($sformatf("div3.s_en_c%0d", c), se3, ee);
      chk($sformatf("div3.done_c%0d", c), d3, ed);
    end
    @(negedge clk);
    chk("div3.rx", rx3, 8'h01);
    chk("div3.ones", ones3 - o0, 3);
    chk("div3.en_count", en3 - e0, 8);
    chk("div3.done_count", dn3 - n0, 1);

    // Load during SHIFT ignored: FF stays FF.
    n0 = dn1;
    send1(8'hFF);
    repeat (2) @(negedge clk);
    lv1 = 1'b1; p1 = 8'h00;
    @(negedge clk);
    lv1 = 1'b0;
    wait_done(0, 40, "ign.done");
    chk("ign.rx", rx1, 8'hFF);
    repeat (3) @(negedge clk);
    chk("ign.done_count", dn1 - n0, 1);

    // Reset mid-frame aborts; next frame starts from bit 0.
    n0 = dn1;
    send1(8'hF0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort.load_ready", r1, 1'b1);
    chk("abort.busy", b1, 1'b0);
    chk("abort.s_out", so1, 1'b0);
    chk("abort.s_en", se1, 1'b0);
    e0 = en1;
    repeat (30) @(negedge clk);
    chk("abort.no_s_en", en1 - e0, 0);
    chk("abort.no_done", dn1 - n0, 0);
    send1(8'h81);
    wait_done(0, 40, "abort.next_done");
    chk("abort.rx_next", rx1, 8'h81);
    repeat (3) @(negedge clk);
    chk("abort.done_count", dn1 - n0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "time limit");
  end

endmodule
